// File: rtl/mss_uart_rx_fifo.sv
// UART receiver for an MSS TXD line: 2-flop synchronizer, mid-bit sampling FSM,
// optional parity, and a small first-word-fall-through FIFO with valid/ready output.
module mss_uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        FAB_CLK,
    input  logic                        MSS_RESET_N,
    input  logic                        RXD,
    output logic [7:0]                  RX_DATA,
    output logic                        RX_VALID,
    input  logic                        RX_READY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
    output logic                        FRAME_ERR,
    output logic                        PARITY_ERR,
    output logic                        OVERRUN
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             PAR_ON     = (PARITY_EN != 0);
    localparam logic             PAR_ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // RXD synchronizer (idles high, so it resets high)
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic rxd_s;

    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            sync1_reg <= 1'b1;
            rxd_s     <= 1'b1;
        end else begin
            sync1_reg <= RXD;
            rxd_s     <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             perr_reg, perr_next;
    logic             frame_err_reg, frame_err_next;
    logic             parity_err_reg, parity_err_next;
    logic             push_req;

    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            perr_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            perr_reg       <= perr_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + CNT_ONE;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        perr_next       = perr_reg;
        push_req        = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxd_s) begin
                    state_next = S_START;
                    perr_next  = 1'b0;
                end
            end

            // Re-check the line half a bit in to reject glitches
            S_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        bit_next   = '0;
                    end
                end
            end

            S_DATA: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next   = '0;
                    shift_next = {rxd_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = PAR_ON ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next   = '0;
                    perr_next  = ((^shift_reg) ^ rxd_s) != PAR_ODD;
                    state_next = S_STOP;
                end
            end

            // Stop is sampled mid-bit, so IDLE is back in time for a back-to-back start
            S_STOP: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next = '0;
                    if (!rxd_s) begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end else if (perr_reg) begin
                        parity_err_next = 1'b1;
                        state_next      = S_IDLE;
                    end else begin
                        push_req   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end

            S_BREAK: begin
                cnt_next = '0;
                if (rxd_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             overrun_reg, overrun_next;
    logic [7:0]       head_next;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign pop          = rx_valid_reg && RX_READY;
    assign full         = (count_reg == COUNT_FULL);
    assign push_ok      = push_req && (!full || pop);
    assign overrun_next = push_req && full && !pop;
    assign wr_ptr_next  = push_ok ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    assign rd_ptr_next  = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + COUNT_ONE;
        end else if (!push_ok && pop) begin
            count_next = count_reg - COUNT_ONE;
        end
    end

    // New head is the incoming byte when it lands in the slot the read pointer moves to
    always_comb begin
        head_next     = mem[rd_ptr_next];
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = shift_reg;
        end
        rx_valid_next = (count_next != '0);
        rx_data_next  = rx_valid_next ? head_next : rx_data_reg;
    end

    always_ff @(posedge FAB_CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign RX_DATA    = rx_data_reg;
    assign RX_VALID   = rx_valid_reg;
    assign FIFO_COUNT = count_reg;
    assign FRAME_ERR  = frame_err_reg;
    assign PARITY_ERR = parity_err_reg;
    assign OVERRUN    = overrun_reg;

endmodule

// File: tb/tb_mss_uart_rx_fifo.sv
// Bench for mss_uart_rx_fifo: directed scenarios plus random frames against a
// queue-based model of the receive path, compared on every falling clock edge.
`timescale 1ns/1ps
module tb_mss_uart_rx_fifo;

    localparam int C = 16;
    localparam int D = 4;
    // edges from the start-bit falling edge to the stop sample: 2 sync + 1 detect + half bit + 9 bits
    localparam int STOP_LAT = 3 + C / 2 + 9 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       fe, pe, ov;
    logic       rxd_p, rx_ready_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic [2:0] fifo_count_p;
    logic       fe_p, pe_p, ov_p;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    int last_start = 0;
    int rise_cyc = -1;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, pe_p_cnt = 0;

    logic [7:0] mq[$];
    logic [7:0] popped[$];
    int         ev_kind[int];
    logic [7:0] ev_byte[int];
    logic [7:0] exp_data = 8'h00;
    logic       exp_fe = 1'b0, exp_ov = 1'b0;

    mss_uart_rx_fifo #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(D)) u_dut (
        .FAB_CLK(clk), .MSS_RESET_N(rst_n), .RXD(rxd), .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .RX_READY(rx_ready), .FIFO_COUNT(fifo_count), .FRAME_ERR(fe), .PARITY_ERR(pe), .OVERRUN(ov));

    mss_uart_rx_fifo #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(D)) u_par (
        .FAB_CLK(clk), .MSS_RESET_N(rst_n), .RXD(rxd_p), .RX_DATA(rx_data_p), .RX_VALID(rx_valid_p),
        .RX_READY(rx_ready_p), .FIFO_COUNT(fifo_count_p), .FRAME_ERR(fe_p), .PARITY_ERR(pe_p), .OVERRUN(ov_p));

    initial forever #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // consumer ready: 0 = hold off, 1 = always ready, otherwise random
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // reference model: frame outcomes land on their stop-sample edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            mq.delete();
            ev_kind.delete();
            ev_byte.delete();
            exp_data = 8'h00;
            exp_fe   = 1'b0;
            exp_ov   = 1'b0;
        end else begin
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            if (mq.size() > 0 && rx_ready) void'(mq.pop_front());
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 1) begin
                    if (mq.size() == D) exp_ov = 1'b1;
                    else mq.push_back(ev_byte[cyc]);
                end else begin
                    exp_fe = 1'b1;
                end
                ev_kind.delete(cyc);
                ev_byte.delete(cyc);
            end
            if (mq.size() > 0) exp_data = mq[0];
        end
    end

    // per-cycle compare and monitors
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (rx_data !== exp_data || rx_valid !== (mq.size() != 0) || fifo_count !== 3'(mq.size())
                    || fe !== exp_fe || pe !== 1'b0 || ov !== exp_ov) begin
                    errors++;
                    $display("FAIL model_cmp cycle %0d got data=%02h valid=%0b count=%0d fe=%0b pe=%0b ov=%0b required data=%02h valid=%0b count=%0d fe=%0b pe=0 ov=%0b",
                             cyc, rx_data, rx_valid, fifo_count, fe, pe, ov,
                             exp_data, mq.size() != 0, mq.size(), exp_fe, exp_ov);
                end
                if (rx_valid && !prev_valid) rise_cyc = cyc;
                if (rx_valid && rx_ready) popped.push_back(rx_data);
                if (fe) fe_cnt++;
                if (pe) pe_cnt++;
                if (ov) ov_cnt++;
                if (pe_p) pe_p_cnt++;
            end
            prev_valid = rx_valid;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int last_pop(input int back);
        if (popped.size() > back) return int'(popped[popped.size() - 1 - back]);
        return -1;
    endfunction

    // caller is always just after a rising edge
    task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low,
                        input bit par_line, input bit pbit);
        int   nb;
        int   due;
        logic v;
        nb = par_line ? 11 : 10;
        last_start = cyc;
        if (!par_line) begin
            due          = cyc + STOP_LAT;
            ev_byte[due] = b;
            ev_kind[due] = stop_ok ? 1 : 2;
        end
        for (int i = 0; i < nb; i++) begin
            if (i == 0)           v = 1'b0;
            else if (i <= 8)      v = b[i-1];
            else if (i == nb - 1) v = stop_ok;
            else                  v = pbit;
            if (par_line) rxd_p = v;
            else          rxd   = v;
            idle(C);
        end
        if (!stop_ok) idle(hold_low);
        if (par_line) rxd_p = 1'b1;
        else          rxd   = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rxd        = 1'b1;
        rxd_p      = 1'b1;
        rx_ready_p = 1'b0;
        idle(2);
        check("reset_data", int'(rx_data), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_fe", int'(fe), 0);
        check("reset_pe", int'(pe), 0);
        check("reset_ov", int'(ov), 0);
        rst_n = 1'b1;
        idle(4);

        // single byte, held in the FIFO
        send(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        idle(2);
        check("single_valid", int'(rx_valid), 1);
        check("single_data", int'(rx_data), 'hA5);
        check("single_count", int'(fifo_count), 1);
        check("single_latency", rise_cyc - last_start, 155);
        check("single_no_err", fe_cnt + pe_cnt + ov_cnt, 0);
        ready_mode = 1;
        idle(4);
        check("single_pop", last_pop(0), 'hA5);

        // glitch shorter than half a bit
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(40);
        check("glitch_pops", popped.size(), 1);
        send(8'h3C, 1'b1, 0, 1'b0, 1'b0);
        idle(4);
        check("glitch_next", last_pop(0), 'h3C);

        // framing error with line held low
        send(8'h55, 1'b0, 40, 1'b0, 1'b0);
        idle(6);
        check("frame_pulses", fe_cnt, 1);
        check("frame_count", int'(fifo_count), 0);
        send(8'h81, 1'b1, 0, 1'b0, 1'b0);
        idle(4);
        check("frame_next", last_pop(0), 'h81);

        // overrun on the fifth back-to-back byte
        ready_mode = 0;
        idle(2);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 0, 1'b0, 1'b0);
        idle(3);
        check("ovr_count", int'(fifo_count), 4);
        check("ovr_pulses", ov_cnt, 1);
        ready_mode = 1;
        idle(8);
        for (int i = 0; i < 4; i++) check("ovr_order", last_pop(3 - i), i + 1);

        // even parity on the second instance
        send(8'h07, 1'b1, 0, 1'b1, 1'b0);
        idle(4);
        check("par_bad_pulse", pe_p_cnt, 1);
        check("par_bad_valid", int'(rx_valid_p), 0);
        send(8'h07, 1'b1, 0, 1'b1, 1'b1);
        idle(4);
        check("par_good_valid", int'(rx_valid_p), 1);
        check("par_good_data", int'(rx_data_p), 'h07);
        check("par_good_pulses", pe_p_cnt + int'(fe_p), 1);

        // asynchronous reset mid-DATA with two bytes queued
        ready_mode = 0;
        idle(2);
        send(8'hAA, 1'b1, 0, 1'b0, 1'b0);
        send(8'h5A, 1'b1, 0, 1'b0, 1'b0);
        idle(2);
        check("rst_pre_count", int'(fifo_count), 2);
        rxd = 1'b0;
        idle(3 * C);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", int'(rx_data), 0);
        check("rst_mid_valid", int'(rx_valid), 0);
        check("rst_mid_count", int'(fifo_count), 0);
        check("rst_mid_par_count", int'(fifo_count_p), 0);
        rxd = 1'b1;
        idle(4);
        rst_n      = 1'b1;
        ready_mode = 1;
        idle(4);
        send(8'hC3, 1'b1, 0, 1'b0, 1'b0);
        idle(4);
        check("rst_after", last_pop(0), 'hC3);

        // random frames, random consumer
        ready_mode = 2;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                send(b, 1'b0, $urandom_range(0, 30), 1'b0, 1'b0);
                idle(5 + $urandom_range(0, 5));
            end else begin
                send(b, 1'b1, 0, 1'b0, 1'b0);
                idle($urandom_range(0, 12));
            end
        end
        ready_mode = 1;
        idle(20);
        check("final_count", int'(fifo_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mss_uart_rx_fifo.md
Name: mss_uart_rx_fifo

Overview:
- Fabric-side UART receiver that terminates a UART transmit line driven by the MSS (UART_0_TXD or UART_1_TXD) and delivers received bytes to fabric logic.
- Synchronizes RXD, validates start bit, samples 8 data bits LSB-first, with optional parity and one stop bit.
- Buffers good bytes in a small first-word-fall-through FIFO with a valid/ready read interface.
- Error conditions are reported as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 347, fabric clocks per UART bit (40 MHz / 115200); legal range >= 8.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.

Ports:
- FAB_CLK  input  1  fabric clock; all logic is on the rising edge.
- MSS_RESET_N  input  1  reset, asynchronous, active-low.
- RXD  input  1  serial line from MSS UART TXD; asynchronous; idles high.
- RX_DATA  output  8  byte at the FIFO head.
- RX_VALID  output  1  FIFO not empty.
- RX_READY  input  1  consumer accepts RX_DATA when RX_VALID && RX_READY.
- FIFO_COUNT  output  log2(FIFO_DEPTH)+1  current occupancy.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- PARITY_ERR  output  1  one-cycle pulse: parity mismatch.
- OVERRUN  output  1  one-cycle pulse: good byte dropped because the FIFO is full.

Behaviour:
- Clock and reset:
  - One clock, FAB_CLK.
  - Reset is asynchronous and active-low on MSS_RESET_N.
  - Reset takes effect immediately regardless of FAB_CLK.
- Reset values:
  - RX_DATA = 0, RX_VALID = 0, FIFO_COUNT = 0.
  - FRAME_ERR, PARITY_ERR and OVERRUN = 0.
  - FSM = IDLE; synchronizer flops = 1.
  - An assertion mid-frame discards the partial byte and empties the FIFO.
- Synchronizer: two flops, reset to 1. rxd_s is the second flop output. The FSM sees RXD 2 cycles late.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. It reloads to 0 on each state entry.
- FSM states and transitions:
  - IDLE: on rxd_s = 0 (falling edge), go to START with cnt = 0.
  - START: at cnt = CLKS_PER_BIT/2 - 1 (mid start bit), sample rxd_s.
    - rxd_s = 1: false start, return to IDLE with no pulse.
    - rxd_s = 0: go to DATA, bit index 0.
  - DATA: sample rxd_s every CLKS_PER_BIT clocks, mid-bit, and shift in LSB first.
    - After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample the parity bit one bit time later.
    - Error when XOR(data, parity bit) != PARITY_ODD; the error is held until the stop sample.
  - STOP: sample one bit time later.
    - rxd_s = 0: FRAME_ERR pulse, byte discarded, go to BREAK.
    - rxd_s = 1, parity error: PARITY_ERR pulse, byte discarded, go to IDLE.
    - rxd_s = 1, no error: push byte, go to IDLE.
  - BREAK: wait for rxd_s = 1, then go to IDLE. No new start is detected while the line stays low.
- Error pulses: FRAME_ERR takes priority; both frame and parity errors give FRAME_ERR only. Pulses assert in the cycle after the stop sample.
- FIFO:
  - First-word-fall-through; RX_DATA and RX_VALID are registered from the head and count.
  - Push latency: a good stop sample at cycle N gives RX_VALID = 1 at cycle N+1 (FIFO previously empty).
  - Pop when RX_VALID && RX_READY; the next head appears the following cycle.
  - RX_DATA holds its last value when empty.
- FIFO boundary cases:
  - Push when full without a simultaneous pop: byte dropped, OVERRUN pulse, contents and count unchanged.
  - Push and pop in the same cycle when full: push accepted, count unchanged, no OVERRUN.
  - Push and pop in the same cycle when empty cannot occur, because RX_VALID = 0 in that cycle.
  - Pointers wrap modulo FIFO_DEPTH; FIFO_COUNT saturates at FIFO_DEPTH by construction.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE is re-entered half a bit before the stop bit ends.

Test Plan:
- Bench settings: CLKS_PER_BIT = 16, FIFO_DEPTH = 4, PARITY_EN = 0.
- Single byte: send 0xA5, RX_READY = 0 -> RX_VALID rises 1 cycle after the stop sample; RX_DATA = 0xA5; FIFO_COUNT = 1; no error pulses.
- Glitch: RXD low for 5 clocks then high -> FSM returns to IDLE; no push, no pulses. Then send 0x3C -> received correctly.
- Framing: send 0x55 with stop bit 0 and the line held low for 40 clocks -> one FRAME_ERR pulse; FIFO_COUNT stays 0. Then send 0x81 -> received as 0x81.
- Overrun: with RX_READY = 0, send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back -> FIFO_COUNT = 4; OVERRUN pulses once on 0x05. Pops then return 0x01..0x04 in order.
- Parity (PARITY_EN = 1, PARITY_ODD = 0): send 0x07 with parity bit 0 -> PARITY_ERR pulse, no push. Send 0x07 with parity bit 1 -> pushed.
- Reset: assert MSS_RESET_N low mid-DATA with 2 bytes queued -> all outputs take reset values immediately. After release, send 0xC3 -> received as 0xC3.
